// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder_pkg : shared FSM state type and parameter-legality helper
// Revision: 1.0
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int MIN_WIDTH = 2;

   function automatic bit params_ok(input int width, input int digit);
      return (width >= MIN_WIDTH) && (digit >= 1) && ((width % digit) == 0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_digit_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// digit_adder : combinational DIGIT-bit ripple-carry chain of full adders
// Revision: 1.0
// ---------------------------------------------------------------------------
module full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (ci & (x ^ y));
endmodule

module digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             cmsb
);
   logic [DIGIT:0] w_c;

   assign w_c[0] = ci;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      full_adder u_fa (
         .x  (x[i]),
         .y  (y[i]),
         .ci (w_c[i]),
         .s  (s[i]),
         .co (w_c[i+1])
      );
   end

   assign co   = w_c[DIGIT];
   // Carry into the top bit of this digit; only meaningful on the final digit.
   assign cmsb = w_c[DIGIT-1];
endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_adder : DIGIT-bits-per-cycle serial adder, result latched on DONE
// Revision: 1.0
// ---------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   import serial_adder_pkg::*;

   localparam int             N      = WIDTH / DIGIT;
   localparam int             CW     = $clog2(N) + 1;
   localparam logic [CW-1:0]  C_LAST = CW'(N - 1);

   if (!params_ok(WIDTH, DIGIT)) begin : g_param_check
      $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
   end

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_load;
   logic             w_step;
   logic             w_last;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] w_a_nxt;
   logic             r_c;
   logic [CW-1:0]    r_cnt;
   logic [DIGIT-1:0] w_s;
   logic             w_co;
   logic             w_cmsb;

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit (
      .x    (r_a[DIGIT-1:0]),
      .y    (r_b[DIGIT-1:0]),
      .ci   (r_c),
      .s    (w_s),
      .co   (w_co),
      .cmsb (w_cmsb)
   );

   // Sum digits are shifted into the top of the A register as its digits are consumed.
   if (N == 1) begin : g_single
      assign w_a_nxt = w_s;
   end else begin : g_shift
      assign w_a_nxt = {w_s, r_a[WIDTH-1:DIGIT]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            busy   = 1'b1;
            w_step = 1'b1;
            if (r_cnt == C_LAST) begin
               w_last      = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= 1'b0;
         r_cnt    <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (w_load) begin
         r_a   <= a;
         r_b   <= b;
         r_c   <= cin;
         r_cnt <= '0;
      end else if (w_step) begin
         r_a   <= w_a_nxt;
         r_b   <= r_b >> DIGIT;
         r_c   <= w_co;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            sum      <= w_a_nxt;
            cout     <= w_co;
            overflow <= w_co ^ w_cmsb;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1: bits added per cycle; SHALL be >= 1 and divide WIDTH exactly, otherwise elaboration SHALL fail.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  request; samples a, b, cin when accepted.
REQ-006 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in to bit 0.
REQ-009 busy  output  1  high while an addition is in progress.
REQ-010 done  output  1  one-cycle pulse: result valid.
REQ-011 sum  output  WIDTH  registered result a+b+cin mod 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.
REQ-013 overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-014 FSM states IDLE, RUN, DONE; N = WIDTH/DIGIT digit steps per operation.
REQ-015 IDLE or DONE with start=1 -> latch a, b, cin into shift registers, clear digit counter, next state RUN.
REQ-016 RUN: each cycle add lowest DIGIT bits of both operand registers plus carry register, shift result digit into sum register LSB-first by DIGIT, update carry register, increment counter.
REQ-017 RUN after the Nth digit -> DONE; DONE lasts exactly one cycle, then IDLE unless start accepted.
REQ-018 Latency: start accepted at edge k -> done=1 during cycle k+N+1 (N RUN cycles, then DONE).
REQ-019 busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-020 sum, cout, overflow SHALL update only on entry to DONE and hold until the next DONE entry; no intermediate values visible.
REQ-021 start during RUN SHALL be ignored; operands and count unaffected.
REQ-022 start during DONE SHALL be accepted (back-to-back); done still pulses that cycle with the old result.
REQ-023 a, b, cin changing after acceptance SHALL not affect the result.
REQ-024 Counter width clog2(N)+1 minimum; no wrap within an operation.
REQ-025 overflow uses carry into MSB captured during the final digit.

Reset
REQ-026 rst_n low: state IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, counter, carry and operand registers 0, immediately regardless of clk.
REQ-027 Reset during RUN aborts the operation; no done pulse; outputs read 0.
REQ-028 First start after rst_n rises is accepted at the first clk edge with rst_n high.

Structure
REQ-029 Shared package holds the state enum (IDLE, RUN, DONE) and a width-check helper constant; no per-instance parameters in the package.
REQ-030 One sub-module digit_adder: combinational DIGIT-bit ripple-carry chain built from the team's full adder, ports x, y, ci, s, co, cmsb (carry into top bit).
REQ-031 Total RTL 120-400 lines; no multipliers, no WIDTH-wide adder in serial_adder itself.

Verification
REQ-032 WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 -> done at cycle k+9, sum=0x00, cout=1, overflow=0.
REQ-033 WIDTH=8, DIGIT=1: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1; a=0x80, b=0x80 -> sum=0x00, cout=1, overflow=1.
REQ-034 WIDTH=8, DIGIT=4: a=0x3C, b=0x4B, cin=1 -> done at k+3, sum=0x88, cout=0, overflow=1; start pulsed in RUN with other operands -> ignored, same result.
REQ-035 Back-to-back: start held high continuously, operands changed each op -> done pulses every N+1 cycles, each sum matches its own operands.
REQ-036 Reset: rst_n low for 1 cycle mid-RUN -> busy, done, sum, cout, overflow 0 asynchronously; no done pulse; next operation correct.
REQ-037 WIDTH=4, DIGIT in {1,2,4}: exhaustive a, b, cin (512 cases) -> sum, cout, overflow match a+b+cin reference model.
